// File: rtl/rst_pulse_gen_if.sv
// Request/pulse bundle between a reset requester and rst_pulse_gen.
// Carries the raw request in and the clean pulse, busy flag and pulse count out.
interface rst_pulse_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             rst_req;
    logic             ar_out;
    logic             busy;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (output rst_req, input ar_out, input busy, input pulse_cnt);
    modport slave  (input rst_req, output ar_out, output busy, output pulse_cnt);
endinterface

// File: rtl/rst_pulse_gen.sv
// Debounces a raw reset request and issues a clean, registered, fixed-width pulse,
// followed by a hold-off window; counts issued pulses with saturation.
module rst_pulse_gen #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             ar,
    rst_pulse_gen_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StDebounce, StAssert, StHoldoff} state_e;

    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             ar_out_q, ar_out_d;

    always_ff @(posedge clk) begin
        if (ar) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            ar_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            ar_out_q    <= ar_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        ar_out_d    = ar_out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.rst_req) begin
                    // A single-cycle debounce skips straight to the pulse.
                    if (DEB_CYCLES == 1) begin
                        state_d  = StAssert;
                        cnt_d    = '0;
                        ar_out_d = 1'b1;
                    end else begin
                        state_d = StDebounce;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StDebounce: begin
                if (!bus.rst_req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d  = StAssert;
                    cnt_d    = '0;
                    ar_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAssert: begin
                if (cnt_q == PulseLast) begin
                    state_d  = StHoldoff;
                    cnt_d    = '0;
                    ar_out_d = 1'b0;
                    if (pulse_cnt_q != CntMax) pulse_cnt_d = pulse_cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHoldoff: begin
                if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ar_out    = ar_out_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Scoreboard bench for rst_pulse_gen: default instance plus a short-debounce, 3-bit-counter
// instance, both checked every cycle against a timeline model of the pulse behaviour.
module tb_rst_pulse_gen;

    localparam int DEB  [2] = '{4, 1};
    localparam int PUL  [2] = '{8, 2};
    localparam int HOLD [2] = '{4, 1};
    localparam int CMAX [2] = '{255, 7};

    logic clk = 1'b0;
    logic ar0 = 1'b1;
    logic ar1 = 1'b1;

    rst_pulse_gen_if #(.CNT_W(8)) bus0 ();
    rst_pulse_gen_if #(.CNT_W(3)) bus1 ();

    rst_pulse_gen #(
        .DEB_CYCLES(4), .PULSE_CYCLES(8), .HOLDOFF_CYCLES(4), .CNT_W(8)
    ) dut0 (
        .clk(clk), .ar(ar0), .bus(bus0)
    );

    rst_pulse_gen #(
        .DEB_CYCLES(1), .PULSE_CYCLES(2), .HOLDOFF_CYCLES(1), .CNT_W(3)
    ) dut1 (
        .clk(clk), .ar(ar1), .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit ar_out;
        bit busy;
        int pc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    bit   done     = 1'b0;

    // Timeline model: a pulse that rises after edge s is high through edge s+P-1,
    // is counted at edge s+P, and re-arms at edge s+P+H.
    int streak  [2] = '{0, 0};
    int start   [2] = '{0, 0};
    bit active  [2] = '{0, 0};
    int npulses [2] = '{0, 0};
    int cyc = 0;

    function automatic exp_t step(int id, bit a, bit r);
        exp_t e;
        int   d;
        if (a) begin
            streak[id]  = 0;
            active[id]  = 1'b0;
            npulses[id] = 0;
        end else if (active[id]) begin
            d = cyc - start[id];
            if (d == PUL[id] && npulses[id] < CMAX[id]) npulses[id]++;
            if (d == PUL[id] + HOLD[id]) begin
                active[id] = 1'b0;
                streak[id] = 0;
            end
        end else if (r) begin
            streak[id]++;
            if (streak[id] == DEB[id]) begin
                active[id] = 1'b1;
                start[id]  = cyc;
                streak[id] = 0;
            end
        end else begin
            streak[id] = 0;
        end
        e.cyc    = cyc;
        e.ar_out = active[id] && ((cyc - start[id]) < PUL[id]);
        e.busy   = active[id] || (streak[id] > 0);
        e.pc     = npulses[id];
        return e;
    endfunction

    task automatic check(string name, int c, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic drive(bit a0, bit a1, bit r);
        @(negedge clk);
        ar0 = a0;
        ar1 = a1;
        bus0.rst_req = r;
        bus1.rst_req = r;
        cyc++;
        q0.push_back(step(0, a0, r));
        q1.push_back(step(1, a1, r));
        started = 1'b1;
    endtask

    // Monitor: one expected record per instance per clock edge.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 || q1.size() == 0) begin
                if (!done) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=%0d/%0d expected=nonempty",
                             q0.size(), q1.size());
                end
            end else begin
                e = q0.pop_front();
                check("i0_ar_out", e.cyc, 32'(bus0.ar_out), int'(e.ar_out));
                check("i0_busy", e.cyc, 32'(bus0.busy), int'(e.busy));
                check("i0_pulse_cnt", e.cyc, 32'(bus0.pulse_cnt), e.pc);
                e = q1.pop_front();
                check("i1_ar_out", e.cyc, 32'(bus1.ar_out), int'(e.ar_out));
                check("i1_busy", e.cyc, 32'(bus1.busy), int'(e.busy));
                check("i1_pulse_cnt", e.cyc, 32'(bus1.pulse_cnt), e.pc);
            end
        end
    end

    initial begin
        int bias;
        bus0.rst_req = 1'b0;
        bus1.rst_req = 1'b0;
        // Reset with the request held high, then release with the request low.
        repeat (2) drive(1'b1, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        // Nominal pulse.
        repeat (4) drive(1'b0, 1'b0, 1'b1);
        repeat (20) drive(1'b0, 1'b0, 1'b0);
        // Glitch shorter than the debounce window.
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0, 1'b0);
        // Held request, toggled while the default instance is in hold-off.
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b0, (i >= 12 && i <= 14) ? i[0] : 1'b1);
        end
        repeat (30) drive(1'b0, 1'b0, 1'b0);
        // Reset in the middle of a pulse, then request again.
        repeat (4) drive(1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b1);
        repeat (30) drive(1'b0, 1'b0, 1'b0);
        // Random traffic with a drifting request bias and rare resets.
        for (int blk = 0; blk < 30; blk++) begin
            bias = int'($urandom_range(1, 9));
            for (int i = 0; i < 100; i++) begin
                drive($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                      int'($urandom_range(0, 9)) < bias);
            end
        end
        done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
